pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage buffer that replaces the fixed, flush-only stage registers between IF/ID/EX/MEM/WB with a valid/ready elastic stage. It adds backpressure, an optional two-entry skid mode that registers `in_ready_o`, synchronous flush, and bubble insertion (a NOP on the data output whenever the stage is empty). It also keeps saturating stall and bubble counters for pipeline performance analysis. One instance sits on each stage boundary of the core, carrying a packed stage bundle.

---
 rtl/pipe_stage_buf.sv | 135 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage with optional two-entry skid mode, flush,
// bubble insertion on an empty stage and saturating stall/bubble counters.
module pipe_stage_buf #(
    parameter int          WIDTH  = 32,
    parameter int          SKID   = 1,
    parameter logic [31:0] BUBBLE = 32'h0000_0013,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] main_data_reg, main_data_next;
    logic [WIDTH-1:0] skb_data_reg, skb_data_next;
    logic             in_fire, out_fire;

    assign out_valid_o = (state_reg != ST_EMPTY);
    assign out_data_o  = out_valid_o ? main_data_reg : BUBBLE_W;
    assign occupancy_o = state_reg;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_reg;
            // Registered ready: low exactly while the skid entry is occupied.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    in_ready_reg <= 1'b1;
                end else begin
                    in_ready_reg <= (state_next != ST_FULL);
                end
            end
            assign in_ready_o = in_ready_reg;
        end else begin : g_single
            assign in_ready_o = (state_reg == ST_EMPTY) || out_ready_i;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            main_data_reg <= '0;
            skb_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            skb_data_reg  <= skb_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        skb_data_next  = skb_data_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_next     = ST_ONE;
                    main_data_next = in_data_i;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_data_next = in_data_i;
                end else if (in_fire) begin
                    // Only reachable with the skid entry present.
                    if (SKID != 0) begin
                        state_next    = ST_FULL;
                        skb_data_next = in_data_i;
                    end
                end else if (out_fire) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_next     = ST_ONE;
                    main_data_next = skb_data_reg;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_next = ST_EMPTY;
        end
    end

    // Index 0 counts stalls, index 1 counts bubbles.
    logic [CNT_W-1:0] cnt_reg [2];
    logic [1:0]       cnt_hit;

    assign cnt_hit[0] = out_valid_o && !out_ready_i;
    assign cnt_hit[1] = !out_valid_o && out_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (clr_cnt_i) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_hit[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt_o  = cnt_reg[0];
    assign bubble_cnt_o = cnt_reg[1];

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a skid instance with 4-bit counters and a
// single-register instance with default counters, checked step by step.
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Skid instance (SKID=1, CNT_W=4)
    logic        flush1, iv1, or1, clr1;
    logic [31:0] id1;
    logic        ir1, ov1;
    logic [31:0] od1;
    logic [1:0]  occ1;
    logic [3:0]  sc1, bc1;

    // Single-register instance (SKID=0, CNT_W=16)
    logic        flush0, iv0, or0, clr0;
    logic [31:0] id0;
    logic        ir0, ov0;
    logic [31:0] od0;
    logic [1:0]  occ0;
    logic [15:0] sc0, bc0;

    int nchk = 0;
    int nerr = 0;

    pipe_stage_buf #(.WIDTH(32), .SKID(1), .BUBBLE(32'h13), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush1),
        .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(id1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1),
        .occupancy_o(occ1), .clr_cnt_i(clr1),
        .stall_cnt_o(sc1), .bubble_cnt_o(bc1)
    );

    pipe_stage_buf #(.WIDTH(32), .SKID(0), .BUBBLE(32'h13), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush0),
        .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(id0),
        .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0),
        .occupancy_o(occ0), .clr_cnt_i(clr0),
        .stall_cnt_o(sc0), .bubble_cnt_o(bc0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush1 = 0; iv1 = 0; or1 = 0; clr1 = 0; id1 = '0;
        flush0 = 0; iv0 = 0; or0 = 0; clr0 = 0; id0 = '0;
        tick(); tick();

        // Reset state
        check("rst_ov1", ov1, 0);
        check("rst_od1", od1, 32'h13);
        check("rst_ir1", ir1, 1);
        check("rst_occ1", occ1, 0);
        check("rst_sc1", sc1, 0);
        check("rst_bc1", bc1, 0);
        check("rst_ov0", ov0, 0);
        check("rst_od0", od0, 32'h13);
        check("rst_ir0", ir0, 1);
        check("rst_occ0", occ0, 0);

        // Streaming, SKID=1
        rst = 0; or1 = 1; iv1 = 1; id1 = 32'h100;
        tick();
        check("str_ov_a", ov1, 1);
        check("str_od_a", od1, 32'h100);
        id1 = 32'h104;
        tick();
        check("str_od_b", od1, 32'h104);
        check("str_ov_b", ov1, 1);
        id1 = 32'h108;
        tick();
        check("str_od_c", od1, 32'h108);
        iv1 = 0;
        tick();
        check("str_ov_end", ov1, 0);
        check("str_od_end", od1, 32'h13);
        check("str_bc", bc1, 1);
        check("str_sc", sc1, 0);

        clr1 = 1; or1 = 0;
        tick();
        clr1 = 0;
        check("clr_bc", bc1, 0);

        // Backpressure, SKID=1
        iv1 = 1; id1 = 32'hA0;
        tick();
        check("bp_od_a", od1, 32'hA0);
        check("bp_ir_one", ir1, 1);
        id1 = 32'hB0;
        tick();
        check("bp_occ_full", occ1, 2);
        check("bp_ir_full", ir1, 0);
        id1 = 32'hC0;
        tick();
        check("bp_occ_hold", occ1, 2);
        check("bp_od_hold", od1, 32'hA0);
        check("bp_sc", sc1, 2);
        or1 = 1;
        tick();
        check("bp_od_b", od1, 32'hB0);
        check("bp_occ_drain", occ1, 1);
        check("bp_ir_rise", ir1, 1);
        tick();
        check("bp_od_c", od1, 32'hC0);
        iv1 = 0;
        tick();
        check("bp_ov_end", ov1, 0);
        check("bp_sc_end", sc1, 2);

        // Flush while FULL with a pending input D
        or1 = 0; iv1 = 1; id1 = 32'h200;
        tick();
        id1 = 32'h204;
        tick();
        check("fl_occ_full", occ1, 2);
        flush1 = 1; id1 = 32'hD0;
        tick();
        flush1 = 0; iv1 = 0;
        check("fl_ov", ov1, 0);
        check("fl_od", od1, 32'h13);
        check("fl_occ", occ1, 0);
        check("fl_ir", ir1, 1);
        check("fl_sc", sc1, 4);

        // Flush in ONE discards a simultaneous accepted input
        iv1 = 1; id1 = 32'h300;
        tick();
        flush1 = 1; id1 = 32'h304;
        tick();
        flush1 = 0; iv1 = 0;
        check("fl1_ov", ov1, 0);
        check("fl1_occ", occ1, 0);
        tick();
        check("fl1_ov_after", ov1, 0);
        check("fl1_od_after", od1, 32'h13);
        check("fl1_sc", sc1, 5);

        // Counter saturation and clear during a stall
        clr1 = 1;
        tick();
        clr1 = 0;
        iv1 = 1; id1 = 32'h400;
        tick();
        iv1 = 0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_sc", sc1, 15);
        tick();
        check("sat_hold", sc1, 15);
        check("sat_od", od1, 32'h400);
        clr1 = 1;
        tick();
        clr1 = 0;
        check("sat_clr", sc1, 0);
        tick();
        check("sat_resume", sc1, 1);

        // SKID=0 simultaneous replace and combinational ready
        iv0 = 1; id0 = 32'h500; or0 = 0;
        #1;
        check("s0_ir_empty", ir0, 1);
        tick();
        check("s0_od_x", od0, 32'h500);
        check("s0_occ", occ0, 1);
        id0 = 32'h504;
        #1;
        check("s0_ir_stall", ir0, 0);
        tick();
        check("s0_od_hold", od0, 32'h500);
        or0 = 1;
        #1;
        check("s0_ir_pass", ir0, 1);
        tick();
        check("s0_od_y", od0, 32'h504);
        check("s0_ov_y", ov0, 1);
        iv0 = 0;
        tick();
        check("s0_ov_end", ov0, 0);
        check("s0_od_end", od0, 32'h13);
        check("s0_sc", sc0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
